trojan_sweep_sequencer: RTL
===========================

# trojan_sweep_sequencer

Synthesizable exhaustive-stimulus controller for the trojan-detection flow. It drives every input pattern 0 … 2^WIDTH−1 into a combinational/sequential DUT under test. For each pattern it waits a programmable settle time, samples the DUT's single-bit output, and hands a (pattern, value) record to a downstream logger over a valid/ready handshake. It also accumulates a 2^WIDTH-bit response signature and a ones-count for on-chip comparison against a golden response.

## Interface
Parameters:
- WIDTH, 4, number of DUT input bits; sweep length is 2^WIDTH (legal 1..8)
- SETTLE, 1, cycles the pattern is held before sampling (legal ≥ 1)

Ports:
- CK  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- abort  input  1  terminate sweep; return to IDLE next edge
- dut_in  output  WIDTH  pattern driven to DUT, registered
- dut_out  input  1  DUT single-bit response
- rec_valid  output  1  record available
- rec_ready  input  1  logger accepts record
- rec_pattern  output  WIDTH  pattern of current record
- rec_value  output  1  sampled dut_out for rec_pattern
- busy  output  1  high in SETTLE, CAPTURE, EMIT
- done  output  1  one-cycle pulse when the full sweep completes
- signature  output  2^WIDTH  bit p = response captured for pattern p
- ones_count  output  WIDTH+1  number of captured 1 responses

## Operation
- States: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- Reset (async, any state) → IDLE; dut_in=0, rec_valid=0, rec_pattern=0, rec_value=0, busy=0, done=0, signature=0, ones_count=0, settle counter=0.
- IDLE: start=1 → SETTLE; pattern=0, dut_in=0, settle counter=0, signature=0, ones_count=0. start=0 → stay.
- SETTLE: counter increments each cycle; when counter==SETTLE−1 → CAPTURE. dut_in stable throughout.
- CAPTURE (1 cycle): rec_value←dut_out, rec_pattern←pattern, signature[pattern]←dut_out, ones_count += dut_out → EMIT.
- EMIT: rec_valid=1. Transfer occurs on an edge with rec_valid & rec_ready.
  - On transfer with pattern==2^WIDTH−1 → DONE.
  - Otherwise → SETTLE with pattern+1, dut_in=pattern+1, counter=0.
  - rec_ready=0 → stay; rec_pattern, rec_value and dut_in are held.
- DONE (1 cycle): done=1, busy=0, rec_valid=0 → IDLE. signature and ones_count hold until the next start or reset.
- abort=1 in SETTLE, CAPTURE or EMIT → IDLE next edge. rec_valid drops, done is not pulsed, dut_in returns to 0. The partial signature and ones_count are retained. abort takes priority over a same-cycle transfer or capture.
- abort and start together in IDLE: abort wins; remain IDLE.
- start while busy or in DONE: ignored.
- Pattern counter never wraps: the terminal pattern always exits through DONE.

## Timing
- start sampled at edge t0 → dut_in=0 valid after t0; CAPTURE at edge t0+SETTLE; rec_valid high from t0+SETTLE+1.
- With rec_ready tied high, each pattern costs SETTLE+2 cycles.
- done is high in the cycle after edge t0+2^WIDTH·(SETTLE+2), i.e. the full sweep plus 1 cycle.
- dut_out is sampled exactly SETTLE cycles after dut_in changes; the DUT path must settle within that.
- Each backpressure cycle (rec_ready=0 in EMIT) adds exactly one cycle; there are no lost or duplicated records.
- All outputs are registered; none combinationally depends on rec_ready or dut_out.

## Test plan
- WIDTH=4, SETTLE=1, dut_out = XOR of dut_in, rec_ready=1, start pulse → 16 records, patterns 0..15 in order, signature=16'h6996, ones_count=8, single done pulse 49 cycles after start.
- Same setup, rec_ready low for 5 cycles while rec_pattern=3 → rec_valid held, rec_pattern=3, dut_in=3 stable; sweep completes 5 cycles later with an identical signature.
- SETTLE=3, dut_out = dut_in[0] & dut_in[3] → each record 5 cycles apart; signature=16'hAA00, ones_count=4.
- abort asserted while rec_pattern=7 in EMIT → IDLE next edge, rec_valid=0, no done pulse, dut_in=0, signature bits 0..7 retained.
- reset asserted asynchronously mid-SETTLE (between clock edges) → all outputs zero immediately; the next start runs a full clean sweep.
- start re-pulsed during a sweep and during DONE → ignored; exactly 16 records and one done pulse.

Source files
------------

// File: rtl/trojan_sweep_sequencer.sv
// trojan_sweep_sequencer
// Walks every WIDTH-bit input pattern into a device under test, waits SETTLE
// cycles per pattern, samples the single-bit response and offers a
// (pattern, value) record to a logger over valid/ready. A per-pattern
// response signature and a ones-count are accumulated alongside.
module trojan_sweep_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [WIDTH-1:0]        dut_in,
    input  logic                    dut_out,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [WIDTH-1:0]        rec_pattern,
    output logic                    rec_value,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<WIDTH)-1:0]   signature,
    output logic [WIDTH:0]          ones_count
);

    localparam int NPAT  = 1 << WIDTH;
    // Counter only has to reach SETTLE-1; keep at least one bit.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] LAST_PAT = WIDTH'(NPAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       pattern_q;
    logic [WIDTH-1:0]       pattern_d;
    logic [CNT_W-1:0]       settle_cnt_q;
    logic [WIDTH-1:0]       dut_in_q;
    logic                   rec_valid_q;
    logic [WIDTH-1:0]       rec_pattern_q;
    logic                   rec_value_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NPAT-1:0]        signature_q;
    logic [WIDTH:0]         ones_count_q;

    // Next pattern; only used when the current one is not the terminal one,
    // so the counter never wraps.
    assign pattern_d = pattern_q + WIDTH'(1);

    // Sweep state machine; every output is a register updated here.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            settle_cnt_q  <= '0;
            dut_in_q      <= '0;
            rec_valid_q   <= 1'b0;
            rec_pattern_q <= '0;
            rec_value_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            signature_q   <= '0;
            ones_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        state_q      <= ST_SETTLE;
                        pattern_q    <= '0;
                        dut_in_q     <= '0;
                        settle_cnt_q <= '0;
                        signature_q  <= '0;
                        ones_count_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        rec_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        dut_in_q     <= '0;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == CNT_LAST) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + CNT_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        rec_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        dut_in_q     <= '0;
                        settle_cnt_q <= '0;
                    end else begin
                        rec_value_q            <= dut_out;
                        rec_pattern_q          <= pattern_q;
                        signature_q[pattern_q] <= dut_out;
                        ones_count_q           <= ones_count_q + {{WIDTH{1'b0}}, dut_out};
                        rec_valid_q            <= 1'b1;
                        state_q                <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        rec_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        dut_in_q     <= '0;
                        settle_cnt_q <= '0;
                    end else if (rec_ready) begin
                        rec_valid_q <= 1'b0;
                        if (pattern_q == LAST_PAT) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_SETTLE;
                            pattern_q    <= pattern_d;
                            dut_in_q     <= pattern_d;
                            settle_cnt_q <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    // single-cycle completion pulse; start is not looked at here
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    rec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in      = dut_in_q;
    assign rec_valid   = rec_valid_q;
    assign rec_pattern = rec_pattern_q;
    assign rec_value   = rec_value_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign signature   = signature_q;
    assign ones_count  = ones_count_q;

endmodule
